// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address-width helper and writeback-select encoding
package regfile_pkg;
   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int NRD_DEF  = 2;
   typedef enum logic {WB_ALU = 1'b0, WB_MEM = 1'b1} wb_sel_e;
   function automatic int rf_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, issue arbitration and pending-count popcount
module rf_scoreboard import regfile_pkg::*; #(
   parameter int NREG = NREG_DEF,
   parameter int NRD = NRD_DEF,
   parameter int BYPASS = 1,
   localparam int AW = rf_clog2(NREG)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NRD*AW-1:0] i_raddr,
   output logic [NRD-1:0]    o_rd_busy,
   input  logic              i_issue_valid,
   input  logic [AW-1:0]     i_issue_rd,
   output logic              o_issue_ready,
   input  logic              i_regwr,
   input  logic [AW-1:0]     i_rw,
   input  logic              i_flush,
   output logic              o_wr_ack,
   output logic              o_stray_wb,
   output logic [AW:0]       o_pending_cnt
);
   logic [NREG-1:0] r_busy, w_busy_nxt, w_set, w_clr;
   logic [AW:0]     r_cnt, w_cnt;
   logic            r_wr_ack, r_stray_wb;
   logic            w_commit, w_accept;
   assign w_commit = i_regwr && (i_rw != '0);
   assign o_issue_ready = !i_flush && ((i_issue_rd == '0) || !r_busy[i_issue_rd] || (i_regwr && (i_rw == i_issue_rd)));
   assign w_accept = i_issue_valid && o_issue_ready && (i_issue_rd != '0);
   assign o_wr_ack = r_wr_ack;
   assign o_stray_wb = r_stray_wb;
   assign o_pending_cnt = r_cnt;
   // next busy vector: flush clears everything, otherwise a same-cycle set overrides the clear
   always_comb begin
      w_set = '0;
      w_clr = '0;
      w_set[i_issue_rd] = w_accept;
      w_clr[i_rw] = w_commit;
      w_busy_nxt = i_flush ? '0 : (r_busy & ~w_clr) | w_set;
      w_cnt = '0;
      for (int i = 0; i < NREG; i++) w_cnt = w_cnt + (AW+1)'(w_busy_nxt[i]);
   end
   for (genvar g = 0; g < NRD; g++) begin : g_port
      logic [AW-1:0] w_a;
      assign w_a = i_raddr[g*AW +: AW];
      assign o_rd_busy[g] = r_busy[w_a] && !((BYPASS != 0) && i_regwr && (i_rw == w_a));
   end
   // busy state, registered popcount and one-cycle write status pulses
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy     <= '0;
         r_cnt      <= '0;
         r_wr_ack   <= 1'b0;
         r_stray_wb <= 1'b0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_cnt      <= w_cnt;
         r_wr_ack   <= w_commit;
         r_stray_wb <= w_commit && !r_busy[i_rw];
      end
   end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with write forwarding and a reservation scoreboard
module regfile_scoreboard import regfile_pkg::*; #(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD = NRD_DEF,
   parameter int BYPASS = 1,
   localparam int AW = rf_clog2(NREG)
) (
   input  logic                WrClk,
   input  logic                Rst,
   input  logic [NRD*AW-1:0]   Raddr,
   output logic [NRD*XLEN-1:0] Rdata,
   output logic [NRD-1:0]      RdBusy,
   input  logic                IssueValid,
   input  logic [AW-1:0]       IssueRd,
   output logic                IssueReady,
   input  logic                RegWr,
   input  logic [AW-1:0]       Rw,
   input  logic [XLEN-1:0]     Result,
   input  logic [XLEN-1:0]     DataOut,
   input  logic                MemtoReg,
   input  logic                Flush,
   output logic                WrAck,
   output logic                StrayWb,
   output logic [AW:0]         PendingCnt
);
   logic [XLEN-1:0] r_regs [NREG];
   logic [XLEN-1:0] w_wdata;
   logic            w_commit;
   assign w_commit = RegWr && (Rw != '0);
   assign w_wdata = (wb_sel_e'(MemtoReg) == WB_MEM) ? DataOut : Result;
   // storage; register 0 is never written because a commit needs a nonzero Rw
   always_ff @(posedge WrClk) begin
      if (Rst) for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      else if (w_commit) r_regs[Rw] <= w_wdata;
   end
   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0] w_a;
      assign w_a = Raddr[g*AW +: AW];
      assign Rdata[g*XLEN +: XLEN] = (w_a == '0) ? '0 :
                                     ((BYPASS != 0) && w_commit && (Rw == w_a)) ? w_wdata : r_regs[w_a];
   end
   rf_scoreboard #(.NREG(NREG), .NRD(NRD), .BYPASS(BYPASS)) u_sb (
      .i_clk         (WrClk),
      .i_rst         (Rst),
      .i_raddr       (Raddr),
      .o_rd_busy     (RdBusy),
      .i_issue_valid (IssueValid),
      .i_issue_rd    (IssueRd),
      .o_issue_ready (IssueReady),
      .i_regwr       (RegWr),
      .i_rw          (Rw),
      .i_flush       (Flush),
      .o_wr_ack      (WrAck),
      .o_stray_wb    (StrayWb),
      .o_pending_cnt (PendingCnt)
   );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: random and directed stimulus against a behavioural model, BYPASS=1 and BYPASS=0 side by side
module tb_regfile_scoreboard;
   localparam int XLEN = 32, NREG = 32, NRD = 2, AW = 5;
   logic WrClk = 1'b0;
   always #5 WrClk = ~WrClk;
   logic                Rst = 1'b0, IssueValid = 1'b0, RegWr = 1'b0, MemtoReg = 1'b0, Flush = 1'b0;
   logic [AW-1:0]       IssueRd = '0, Rw = '0;
   logic [NRD*AW-1:0]   Raddr = '0;
   logic [XLEN-1:0]     Result = '0, DataOut = '0;
   logic [NRD*XLEN-1:0] rdata_b, rdata_n;
   logic [NRD-1:0]      busy_b, busy_n;
   logic                rdy_b, rdy_n, ack_b, ack_n, stray_b, stray_n;
   logic [AW:0]         cnt_b, cnt_n;
   regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) u_byp (
      .WrClk(WrClk), .Rst(Rst), .Raddr(Raddr), .Rdata(rdata_b), .RdBusy(busy_b),
      .IssueValid(IssueValid), .IssueRd(IssueRd), .IssueReady(rdy_b),
      .RegWr(RegWr), .Rw(Rw), .Result(Result), .DataOut(DataOut), .MemtoReg(MemtoReg),
      .Flush(Flush), .WrAck(ack_b), .StrayWb(stray_b), .PendingCnt(cnt_b));
   regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) u_nob (
      .WrClk(WrClk), .Rst(Rst), .Raddr(Raddr), .Rdata(rdata_n), .RdBusy(busy_n),
      .IssueValid(IssueValid), .IssueRd(IssueRd), .IssueReady(rdy_n),
      .RegWr(RegWr), .Rw(Rw), .Result(Result), .DataOut(DataOut), .MemtoReg(MemtoReg),
      .Flush(Flush), .WrAck(ack_n), .StrayWb(stray_n), .PendingCnt(cnt_n));

   typedef struct {
      logic [63:0] rd_b;
      logic [63:0] rd_n;
      logic [1:0]  bz_b;
      logic [1:0]  bz_n;
      logic        rdy;
      logic        ack;
      logic        stray;
      logic [5:0]  cnt;
   } exp_t;
   exp_t q[$];
   exp_t me;
   int checks = 0, errors = 0;
   bit tb_vld = 0, armed = 0;

   // reference model: architectural state after the most recent edge
   logic [31:0] m_reg [32];
   bit          m_busy [32];
   bit          m_ack = 0, m_stray = 0;
   int          m_cnt = 0;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   // monitor: pops one expectation per presented cycle and compares both DUTs
   always @(negedge WrClk) begin
      if (tb_vld) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_underflow got 0 expected 1 at %0t", $time);
         end else begin
            me = q.pop_front();
            chk("rdata_bypass", rdata_b, me.rd_b);
            chk("rdata_nobypass", rdata_n, me.rd_n);
            chk("rdbusy_bypass", 64'(busy_b), 64'(me.bz_b));
            chk("rdbusy_nobypass", 64'(busy_n), 64'(me.bz_n));
            chk("issue_ready", {rdy_n, rdy_b}, {me.rdy, me.rdy});
            chk("wr_ack", {ack_n, ack_b}, {me.ack, me.ack});
            chk("stray_wb", {stray_n, stray_b}, {me.stray, me.stray});
            chk("pending_cnt_b", 64'(cnt_b), 64'(me.cnt));
            chk("pending_cnt_n", 64'(cnt_n), 64'(me.cnt));
         end
      end
   end

   task automatic step(input bit rst, input bit iv, input int ird, input bit wr, input int rw,
                       input logic [31:0] res, input logic [31:0] dout, input bit mtr, input bit fl,
                       input int ra0, input int ra1);
      exp_t e;
      logic [31:0] wd;
      bit commit, rdy;
      int ra[2];
      @(posedge WrClk);
      #1;
      Rst = rst; IssueValid = iv; IssueRd = ird[4:0]; RegWr = wr; Rw = rw[4:0];
      Result = res; DataOut = dout; MemtoReg = mtr; Flush = fl;
      Raddr = {ra1[4:0], ra0[4:0]};
      wd = mtr ? dout : res;
      commit = wr && (rw != 0);
      ra[0] = ra0;
      ra[1] = ra1;
      for (int k = 0; k < 2; k++) begin
         e.rd_n[k*32 +: 32] = (ra[k] == 0) ? 32'd0 : m_reg[ra[k]];
         e.rd_b[k*32 +: 32] = (commit && rw == ra[k]) ? wd : e.rd_n[k*32 +: 32];
         e.bz_n[k] = m_busy[ra[k]];
         e.bz_b[k] = m_busy[ra[k]] && !(wr && rw == ra[k]);
      end
      rdy = !fl && (ird == 0 || !m_busy[ird] || (wr && rw == ird));
      e.rdy = rdy;
      e.ack = m_ack;
      e.stray = m_stray;
      e.cnt = 6'(m_cnt);
      if (armed) q.push_back(e);
      tb_vld = armed;
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[i] = 0;
            m_busy[i] = 0;
         end
         m_ack = 0;
         m_stray = 0;
      end else begin
         m_ack = commit;
         m_stray = commit && !m_busy[rw];
         if (commit) m_reg[rw] = wd;
         if (fl) for (int i = 0; i < 32; i++) m_busy[i] = 0;
         else begin
            if (commit) m_busy[rw] = 0;
            if (iv && rdy && ird != 0) m_busy[ird] = 1;
         end
      end
      m_cnt = 0;
      for (int i = 0; i < 32; i++) m_cnt += int'(m_busy[i]);
      armed = 1;
   endtask

   task automatic idle(input int ra0, input int ra1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1);
   endtask

   function automatic int ra();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
   endfunction

   task automatic rnd_step();
      step($urandom_range(0, 60) == 0, 1'($urandom_range(0, 1)), ra(), 1'($urandom_range(0, 1)), ra(),
           $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, ra(), ra());
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_reg[i] = 0;
         m_busy[i] = 0;
      end
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(0, 1);
      for (int i = 0; i < 40; i++) rnd_step();
      step(1, 1, 6, 1, 6, 32'h55, 32'h66, 0, 1, 6, 2);
      for (int i = 0; i < 8; i++) step(0, 0, i * 4 + 1, 0, 0, 0, 0, 0, 0, i * 4, i * 4 + 3);
      step(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(5, 0);
      step(0, 0, 0, 1, 5, 32'h0, 32'hDEADBEEF, 1, 0, 5, 0);
      idle(5, 0);
      step(0, 1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
      step(0, 1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
      step(0, 1, 7, 1, 7, 32'hA5A5, 0, 0, 0, 7, 0);
      idle(7, 0);
      step(0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0, 0);
      idle(0, 0);
      step(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 10, 1, 4, 32'hCAFE0004, 0, 0, 1, 4, 3);
      idle(4, 10);
      step(0, 0, 0, 1, 12, 32'h0BADF00D, 0, 0, 0, 12, 12);
      idle(12, 0);
      step(0, 0, 0, 1, 12, 32'h12121212, 0, 0, 0, 12, 0);
      idle(12, 0);
      for (int i = 0; i < 400; i++) rnd_step();
      @(posedge WrClk);
      #1;
      tb_vld = 0;
      repeat (3) @(negedge WrClk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL queue_drain got %0d expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
